// File: rtl/dma_controller.sv
// Burst DMA engine: on a cmd rising edge, requests the data-memory bus and
// writes NUM_BURSTS bursts of BURST_WORDS words from the device, then pulses dma_end_int.
module dma_controller #(
  parameter int                    WORD_SIZE   = 16,
  parameter logic [WORD_SIZE-1:0]  BASE_ADDR   = 16'h01F4,
  parameter int                    BURST_WORDS = 4,
  parameter int                    NUM_BURSTS  = 3,
  localparam int                   OFF_W       = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1,
  localparam int                   DATA_W      = BURST_WORDS * WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd,
  input  logic                 BG,
  input  logic                 doneWrite_d,
  input  logic [DATA_W-1:0]    dev_data,
  output logic                 BR,
  output logic [OFF_W-1:0]     dev_offset,
  output logic                 d_writeM,
  output logic [WORD_SIZE-1:0] d_address,
  output logic [DATA_W-1:0]    d_data,
  output logic                 dma_end_int
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WRITE   = 3'd2,
    GAP     = 3'd3,
    RELEASE = 3'd4,
    END     = 3'd5
  } state_e;

  localparam logic [OFF_W-1:0] LAST_IDX = OFF_W'(NUM_BURSTS - 1);

  state_e               state_q, state_d;
  logic [OFF_W-1:0]     idx_q, idx_d;
  logic                 cmd_d_q;
  logic                 br_q, br_d;
  logic                 wr_q, wr_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic                 end_q, end_d;
  logic                 start;

  function automatic logic [WORD_SIZE-1:0] burst_addr(input logic [OFF_W-1:0] i);
    return BASE_ADDR + WORD_SIZE'(i) * WORD_SIZE'(BURST_WORDS);
  endfunction

  assign start = cmd & ~cmd_d_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cmd_d_q <= 1'b0;
      br_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cmd_d_q <= cmd;
      br_q    <= br_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      end_q   <= end_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    br_d    = br_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    end_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = REQ;
          br_d    = 1'b1;
          idx_d   = '0;
        end
      end
      REQ: begin
        br_d = 1'b1;
        if (BG) begin
          state_d = WRITE;
          wr_d    = 1'b1;
          addr_d  = burst_addr(idx_q);
          data_d  = dev_data;
        end
      end
      WRITE: begin
        // a completed write takes priority over a simultaneous grant loss
        if (doneWrite_d) begin
          wr_d   = 1'b0;
          addr_d = '0;
          data_d = '0;
          if (idx_q == LAST_IDX) begin
            br_d    = 1'b0;
            state_d = RELEASE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = GAP;
          end
        end else if (!BG) begin
          // grant lost: drop the strobe and retry the whole burst after re-grant
          wr_d    = 1'b0;
          addr_d  = '0;
          data_d  = '0;
          state_d = REQ;
        end
      end
      GAP: begin
        if (BG) begin
          state_d = WRITE;
          wr_d    = 1'b1;
          addr_d  = burst_addr(idx_q);
          data_d  = dev_data;
        end else begin
          state_d = REQ;
        end
      end
      RELEASE: begin
        br_d = 1'b0;
        if (!BG) begin
          end_d   = 1'b1;
          state_d = END;
        end
      end
      END: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        br_d    = 1'b0;
        wr_d    = 1'b0;
        addr_d  = '0;
        data_d  = '0;
      end
    endcase
  end

  assign BR          = br_q;
  assign dev_offset  = idx_q;
  assign d_writeM    = wr_q;
  assign d_address   = addr_q;
  assign d_data      = data_q;
  assign dma_end_int = end_q;

endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller: nominal, delayed grant, spurious start,
// grant loss and mid-transfer reset with hand-computed addresses and data.
module tb_dma_controller;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd;
  logic        BG;
  logic        doneWrite_d;
  logic [63:0] dev_data;
  logic        BR;
  logic [1:0]  dev_offset;
  logic        d_writeM;
  logic [15:0] d_address;
  logic [63:0] d_data;
  logic        dma_end_int;

  int checks   = 0;
  int failures = 0;
  int n_wr     = 0;
  int n_end    = 0;
  int wr0, end0;
  logic wr_prev = 1'b0;

  dma_controller dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cmd         (cmd),
    .BG          (BG),
    .doneWrite_d (doneWrite_d),
    .dev_data    (dev_data),
    .BR          (BR),
    .dev_offset  (dev_offset),
    .d_writeM    (d_writeM),
    .d_address   (d_address),
    .d_data      (d_data),
    .dma_end_int (dma_end_int)
  );

  always #5 clk = ~clk;

  // device presents {offset} in every 16-bit word of the burst
  assign dev_data = {4{{14'b0, dev_offset}}};

  always @(negedge clk) begin
    if (d_writeM && !wr_prev) n_wr++;
    if (dma_end_int) n_end++;
    wr_prev = d_writeM;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_wr();
    for (int i = 0; i < 20; i++) begin
      if (d_writeM) break;
      step();
    end
    chk("wait_wr_timeout", d_writeM, 1'b1);
  endtask

  task automatic do_burst(input logic [15:0] addr, input logic [15:0] w);
    wait_wr();
    chk("burst_addr", d_address, addr);
    chk("burst_data", d_data, {4{w}});
    chk("burst_off", dev_offset, w[1:0]);
    step();
    chk("wr_hold", d_writeM, 1'b1);
    doneWrite_d = 1'b1;
    step();
    doneWrite_d = 1'b0;
    chk("wr_fall", d_writeM, 1'b0);
    chk("addr_idle", d_address, 16'h0);
  endtask

  task automatic start_xfer();
    cmd = 1'b0;
    step();
    cmd = 1'b1;
    step();
    chk("start_br", BR, 1'b1);
    chk("start_off", dev_offset, 2'd0);
    chk("start_wr", d_writeM, 1'b0);
  endtask

  task automatic finish_xfer();
    chk("rel_br", BR, 1'b0);
    chk("rel_end", dma_end_int, 1'b0);
    BG = 1'b0;
    step();
    chk("end_pulse", dma_end_int, 1'b1);
    step();
    chk("end_low", dma_end_int, 1'b0);
    chk("end_br", BR, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0; cmd = 1'b0; BG = 1'b0; doneWrite_d = 1'b0;
    #12;
    chk("rst_br", BR, 1'b0);
    chk("rst_wr", d_writeM, 1'b0);
    chk("rst_addr", d_address, 16'h0);
    chk("rst_data", d_data, 64'h0);
    chk("rst_off", dev_offset, 2'd0);
    chk("rst_end", dma_end_int, 1'b0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_br", BR, 1'b0);
    end

    // nominal transfer, grant two cycles after BR
    wr0 = n_wr; end0 = n_end;
    start_xfer();
    step();
    BG = 1'b1;
    do_burst(16'h01F4, 16'd0);
    do_burst(16'h01F8, 16'd1);
    do_burst(16'h01FC, 16'd2);
    finish_xfer();
    chk("nom_writes", n_wr - wr0, 3);
    chk("nom_ends", n_end - end0, 1);

    // delayed grant
    wr0 = n_wr; end0 = n_end;
    start_xfer();
    for (int i = 0; i < 7; i++) begin
      step();
      chk("dly_br", BR, 1'b1);
      chk("dly_wr", d_writeM, 1'b0);
    end
    BG = 1'b1;
    step();
    chk("dly_first_wr", d_writeM, 1'b1);
    do_burst(16'h01F4, 16'd0);
    do_burst(16'h01F8, 16'd1);
    do_burst(16'h01FC, 16'd2);
    finish_xfer();
    chk("dly_writes", n_wr - wr0, 3);

    // spurious start: cmd held high, re-pulsed during burst 1
    wr0 = n_wr; end0 = n_end;
    start_xfer();
    BG = 1'b1;
    do_burst(16'h01F4, 16'd0);
    cmd = 1'b0;
    step();
    cmd = 1'b1;
    do_burst(16'h01F8, 16'd1);
    do_burst(16'h01FC, 16'd2);
    finish_xfer();
    for (int i = 0; i < 5; i++) step();
    chk("sp_no_restart", BR, 1'b0);
    chk("sp_writes", n_wr - wr0, 3);
    chk("sp_ends", n_end - end0, 1);

    // grant loss during burst 1
    wr0 = n_wr; end0 = n_end;
    start_xfer();
    BG = 1'b1;
    do_burst(16'h01F4, 16'd0);
    wait_wr();
    chk("gl_addr", d_address, 16'h01F8);
    BG = 1'b0;
    step();
    chk("gl_wr_fall", d_writeM, 1'b0);
    chk("gl_br", BR, 1'b1);
    chk("gl_off", dev_offset, 2'd1);
    step();
    step();
    chk("gl_wr_low", d_writeM, 1'b0);
    chk("gl_br_hold", BR, 1'b1);
    BG = 1'b1;
    do_burst(16'h01F8, 16'd1);
    do_burst(16'h01FC, 16'd2);
    finish_xfer();
    chk("gl_writes", n_wr - wr0, 4);
    chk("gl_ends", n_end - end0, 1);

    // reset while writing the last burst
    end0 = n_end;
    start_xfer();
    BG = 1'b1;
    do_burst(16'h01F4, 16'd0);
    do_burst(16'h01F8, 16'd1);
    wait_wr();
    chk("mr_addr", d_address, 16'h01FC);
    #2;
    reset_n = 1'b0;
    cmd = 1'b0;
    #1;
    chk("mr_br", BR, 1'b0);
    chk("mr_wr", d_writeM, 1'b0);
    chk("mr_addr0", d_address, 16'h0);
    chk("mr_data0", d_data, 64'h0);
    chk("mr_off0", dev_offset, 2'd0);
    chk("mr_end0", dma_end_int, 1'b0);
    BG = 1'b0;
    step();
    #3;
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("mr_no_end", n_end - end0, 0);
    chk("mr_idle_br", BR, 1'b0);
    start_xfer();
    BG = 1'b1;
    do_burst(16'h01F4, 16'd0);
    do_burst(16'h01F8, 16'd1);
    do_burst(16'h01FC, 16'd2);
    finish_xfer();
    chk("mr_ends", n_end - end0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
